// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared constants for alu_op_sequencer: data width, ALU
//               opcodes and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DW = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_regfile
// Description : NREGS x 8 register file, one synchronous write port with
//               synchronous reset, three combinational read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] raddr_d,
    output logic [DW-1:0] rdata_d
);

    logic [DW-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];
    assign rdata_d = r_mem[raddr_d];

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issue/writeback stage for the 8-bit ALU. Optional debug read
//               port enabled by ALU_OP_SEQUENCER_DBG_PORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [7:0]    alu_out,
    input  logic          alu_carry,
    output logic          done,
    output logic          flag_z,
    output logic          flag_c,
    output logic          div_err
`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
    ,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
`endif
);

    state_t        r_state;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [3:0]    r_alu_ctrl;
    logic [AW-1:0] r_dst;
    logic          r_done;
    logic          r_flag_z;
    logic          r_flag_c;
    logic          r_div_err;

    logic          w_accept;
    logic          w_exec;
    logic          w_div0;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata_a;
    logic [DW-1:0] w_rdata_b;
    logic [AW-1:0] w_dbg_addr;
    logic [DW-1:0] w_dbg_rdata;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_exec    = (r_state == ST_EXEC);
    assign w_div0    = (r_alu_ctrl == OP_DIV) && (r_alu_b == '0);

    // One write port serves both load-immediate (IDLE) and ALU writeback (EXEC);
    // the two can never coincide because nothing is accepted during EXEC.
    assign w_we    = (w_accept && cmd_ld) || (w_exec && !w_div0);
    assign w_waddr = w_exec ? r_dst   : cmd_dst;
    assign w_wdata = w_exec ? alu_out : cmd_imm;

    alu_seq_regfile #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (cmd_srca),
        .rdata_a (w_rdata_a),
        .raddr_b (cmd_srcb),
        .rdata_b (w_rdata_b),
        .raddr_d (w_dbg_addr),
        .rdata_d (w_dbg_rdata)
    );

`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
    assign w_dbg_addr = dbg_addr;
    assign dbg_data   = w_dbg_rdata;
`else
    logic [DW-1:0] w_dbg_unused;
    assign w_dbg_addr   = '0;
    assign w_dbg_unused = w_dbg_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_dst      <= '0;
            r_done     <= 1'b0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_div_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (cmd_ld) begin
                            r_flag_z <= (cmd_imm == '0);
                            r_done   <= 1'b1;
                        end else begin
                            r_alu_a    <= w_rdata_a;
                            r_alu_b    <= w_rdata_b;
                            r_alu_ctrl <= cmd_op;
                            r_dst      <= cmd_dst;
                            r_state    <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Divide by zero leaves the destination and both flags untouched.
                    if (w_div0) begin
                        r_div_err <= 1'b1;
                    end else begin
                        r_flag_z <= (alu_out == '0);
                        if ((r_alu_ctrl == OP_ADD) || (r_alu_ctrl == OP_SUB)) begin
                            r_flag_c <= alu_carry;
                        end
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctrl = r_alu_ctrl;
    assign done     = r_done;
    assign flag_z   = r_flag_z;
    assign flag_c   = r_flag_c;
    assign div_err  = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with a behavioural
//               ALU and a register-file/flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_ld;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic [7:0]    cmd_imm;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_ctrl;
    logic [7:0]    alu_out;
    logic          alu_carry;
    logic          done;
    logic          flag_z;
    logic          flag_c;
    logic          div_err;
`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.NREGS(NREGS)) dut (
`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
`endif
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ld    (cmd_ld),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .done      (done),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .div_err   (div_err)
    );

    // External ALU: carry is deliberately nonzero for non-ADD/SUB ops so that
    // a flag_c update on the wrong opcode becomes visible.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {(a < b), 8'(a - b)};
            4'd3:    return (b == 8'd0) ? {1'b1, 8'hFF} : {1'b1, 8'(a / b)};
            4'd8:    return {1'b1, a & b};
            4'd9:    return {1'b1, a | b};
            4'd10:   return {1'b1, a ^ b};
            default: return {1'b1, 8'(a + b + {4'b0, op})};
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_f(alu_ctrl, alu_a, alu_b);

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    rf_m [NREGS];
    logic          z_m, c_m, de_m;
    logic [3:0]    p_op;
    logic [AW-1:0] p_dst;
    logic [7:0]    p_a, p_b;
    logic [7:0]    cap_a, cap_b;
    int            acc_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) rf_m[i] = 8'h00;
        z_m = 1'b0; c_m = 1'b0; de_m = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic [3:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic [7:0] imm);
        cmd_ld = ld; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
    endtask

    // Called at posedge+1 with a command driven; returns at posedge+1 after the accept edge.
    task automatic accept();
        int n = 0;
        while (!cmd_ready && n < 8) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        cap_a = alu_a; cap_b = alu_b;
        if (cmd_ld) begin
            rf_m[cmd_dst] = cmd_imm;
            z_m = (cmd_imm == 8'h00);
            chk("ld_done", 32'(done), 32'd1);
            chk("ld_ready", 32'(cmd_ready), 32'd1);
            chk("ld_flag_z", 32'(flag_z), 32'(z_m));
            chk("ld_flag_c", 32'(flag_c), 32'(c_m));
        end else begin
            p_op = cmd_op; p_dst = cmd_dst;
            p_a = rf_m[cmd_srca]; p_b = rf_m[cmd_srcb];
            chk("exec_alu_a", 32'(alu_a), 32'(p_a));
            chk("exec_alu_b", 32'(alu_b), 32'(p_b));
            chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(p_op));
            chk("exec_ready", 32'(cmd_ready), 32'd0);
            chk("exec_done", 32'(done), 32'd0);
        end
    endtask

    task automatic retire();
        logic [8:0] res;
        @(posedge clk); #1;
        res = alu_f(p_op, p_a, p_b);
        if (p_op == 4'd3 && p_b == 8'h00) begin
            de_m = 1'b1;
        end else begin
            rf_m[p_dst] = res[7:0];
            z_m = (res[7:0] == 8'h00);
            if (p_op == 4'd0 || p_op == 4'd1) c_m = res[8];
        end
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_ready", 32'(cmd_ready), 32'd1);
        chk("wb_flag_z", 32'(flag_z), 32'(z_m));
        chk("wb_flag_c", 32'(flag_c), 32'(c_m));
        chk("wb_div_err", 32'(div_err), 32'(de_m));
        chk("wb_hold_a", 32'(alu_a), 32'(p_a));
    endtask

    task automatic send(input logic ld, input logic [3:0] op, input logic [AW-1:0] dst,
                        input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic [7:0] imm);
        drive(ld, op, dst, sa, sb, imm);
        accept();
        cmd_valid = 1'b0;
        if (!ld) retire();
    endtask

`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
    task automatic dbg_scan();
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i); #1;
            chk($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(rf_m[i]));
        end
    endtask
`endif

    typedef struct {
        logic          ld;
        logic [3:0]    op;
        logic [AW-1:0] dst, sa, sb;
        logic [7:0]    imm;
        logic [7:0]    ea, eb;
        logic          ez, ec, ede;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int c0;
        tbl[0] = '{1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'd1, 2'd3, 2'd1, 2'd1, 8'h00, 8'h20, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'd3, 2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 4'd8, 2'd2, 2'd2, 2'd2, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'd8, 2'd3, 2'd0, 2'd1, 8'h00, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 4'd3, 2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'd9, 2'd1, 2'd2, 2'd2, 8'h00, 8'h07, 8'h07, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0;
        drive(1'b0, 4'd0, '0, '0, '0, 8'h00); cmd_valid = 1'b0;
`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
        dbg_addr = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_c, div_err}, 32'd0);
        chk("rst_alu", {12'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        rst = 1'b0; #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);

        // Directed table from the test plan
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].ld, tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm);
            if (i == 0) c0 = acc_cyc;
            if (i == 1) chk("b2b_load_gap", 32'(acc_cyc - c0), 32'd1);
            if (!tbl[i].ld) begin
                chk($sformatf("tbl%0d_a", i), 32'(cap_a), 32'(tbl[i].ea));
                chk($sformatf("tbl%0d_b", i), 32'(cap_b), 32'(tbl[i].eb));
            end
            chk($sformatf("tbl%0d_z", i), 32'(flag_z), 32'(tbl[i].ez));
            chk($sformatf("tbl%0d_c", i), 32'(flag_c), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_de", i), 32'(div_err), 32'(tbl[i].ede));
        end

        // Second command held valid through EXEC; it reads the first one's result
        drive(1'b0, 4'd0, 2'd0, 2'd0, 2'd1, 8'h00);
        accept();
        drive(1'b0, 4'd1, 2'd3, 2'd0, 2'd2, 8'h00);
        chk("held_not_ready", 32'(cmd_ready), 32'd0);
        retire();
        c0 = cyc;
        accept();
        chk("held_accept_cycle", 32'(acc_cyc - c0), 32'd1);
        cmd_valid = 1'b0;
        retire();

        // Reset during EXEC aborts the ADD
        drive(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 8'h00);
        accept();
        rst = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        chk("abort_flags", {29'd0, flag_z, flag_c, div_err}, 32'd0);
        chk("abort_alu", {12'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        rst = 1'b0; #1;
        model_reset();
        chk("abort_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("abort_no_late_done", 32'(done), 32'd0);
        send(1'b0, 4'd10, 2'd0, 2'd2, 2'd3, 8'h00);
        send(1'b0, 4'd10, 2'd0, 2'd0, 2'd1, 8'h00);

        // Randomized commands against the reference model
        for (int n = 0; n < 300; n++) begin
            logic          ld;
            logic [3:0]    op;
            logic [7:0]    imm;
            ld  = ($urandom_range(0, 2) == 0);
            op  = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            send(ld, op, AW'($urandom), AW'($urandom), AW'($urandom), imm);
`ifdef ALU_OP_SEQUENCER_DBG_PORT_EN
            dbg_scan();
`endif
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                chk("idle_no_done", 32'(done), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
